// File: rtl/adder_stim_checker.sv
// adder_stim_checker
//   Self-checking operand source and result monitor for an 8-bit add/subtract
//   unit. Each vector is produced from a 16-bit Galois LFSR and driven onto
//   A_out/B_out/opcode_out. The adder result is sampled two cycles later and
//   compared against an internally computed expected value.
//
// Parameters
//   NUM_VECTORS : vectors per run (1..255)
//   SEED        : LFSR seed loaded on every start (0 is replaced by 16'hACE1)
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : begin a run (honoured in IDLE or DONE only)
//   A_out, B_out, opcode_out : registered operands/opcode (0 add, 1 sub)
//   Sum_in, Carry_in,
//   overflow_in              : adder results, sampled in CHECK
//   busy, done, pass         : run status
//   err_count, vec_count     : mismatching vectors (saturating), vectors checked
//
// Optional feature
//   ADDER_CHK_STOP_ON_ERR_EN : when defined, the first mismatch ends the run,
//                              leaving the failing operands and index visible.

module adder_stim_checker #(
  parameter int          NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] A_out,
  output logic [7:0] B_out,
  output logic       opcode_out,
  input  logic [7:0] Sum_in,
  input  logic       Carry_in,
  input  logic       overflow_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] vec_count
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  NUM_VEC   = 8'(NUM_VECTORS);

  state_t      state;
  logic [15:0] lfsr;

  // Expected-result datapath, driven entirely from the registered operands.
  logic [7:0]  b_eff;
  logic [8:0]  exp_r;
  logic        exp_ovf;
  logic        mismatch;
  logic [7:0]  vec_inc;
  logic        last_vec;
  logic        stop_run;
  logic [15:0] lfsr_adv;

  always_comb begin
    // Subtract is A + ~B + 1, so the opcode doubles as the carry-in.
    b_eff    = opcode_out ? ~B_out : B_out;
    exp_r    = {1'b0, A_out} + {1'b0, b_eff} + {8'd0, opcode_out};
    exp_ovf  = (A_out[7] == b_eff[7]) && (exp_r[7] != A_out[7]);
    mismatch = (Sum_in != exp_r[7:0]) || (Carry_in != exp_r[8]) ||
               (overflow_in != exp_ovf);
    vec_inc  = vec_count + 8'd1;
    last_vec = (vec_inc == NUM_VEC);
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    stop_run = last_vec || mismatch;
`else
    stop_run = last_vec;
`endif
    lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      A_out      <= 8'd0;
      B_out      <= 8'd0;
      opcode_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= 8'd0;
      vec_count  <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr      <= SEED_EFF;
            err_count <= 8'd0;
            vec_count <= 8'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          // Operands take the value before this step's advance.
          lfsr       <= lfsr_adv;
          A_out      <= lfsr[7:0];
          B_out      <= lfsr[15:8];
          opcode_out <= vec_count[0];
          state      <= SETTLE;
        end
        SETTLE: begin
          state <= CHECK;
        end
        CHECK: begin
          vec_count <= vec_inc;
          if (mismatch && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
          if (stop_run) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DRIVE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign pass = done && (err_count == 8'd0);

endmodule

// File: tb/tb_adder_stim_checker.sv
module tb_adder_stim_checker;

  localparam int N  = 16;
  localparam int NS = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] a_out, b_out;
  logic       op_out;
  logic [7:0] sum_in;
  logic       carry_in, ovf_in;
  logic       busy, done, pass;
  logic [7:0] err_count, vec_count;

  logic       start2;
  logic [7:0] a2, b2;
  logic       op2;
  logic [7:0] sum2;
  logic       carry2, ovf2;
  logic       busy2, done2, pass2;
  logic [7:0] err2, vec2;

  int          fault_mode;
  logic [15:0] inj_mask;

  int checks = 0;
  int errors = 0;

  adder_stim_checker #(.NUM_VECTORS(N), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A_out(a_out), .B_out(b_out), .opcode_out(op_out),
    .Sum_in(sum_in), .Carry_in(carry_in), .overflow_in(ovf_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count)
  );

  adder_stim_checker #(.NUM_VECTORS(NS), .SEED(16'hACE1)) dut_sat (
    .clk(clk), .rst(rst), .start(start2),
    .A_out(a2), .B_out(b2), .opcode_out(op2),
    .Sum_in(sum2), .Carry_in(carry2), .overflow_in(ovf2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_count(vec2)
  );

  // Behavioural adder: plain integer arithmetic, returns {overflow, carry, sum}.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic op);
    int ua, ub, sa, sb, u, s;
    logic c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua >= ub);
    end else begin
      u = ua + ub;
      s = sa + sb;
      c = (u > 255);
    end
    return {(s > 127) || (s < -128), c, u[7:0]};
  endfunction

  logic [9:0] g1, g2;
  always_comb begin
    g1       = ref_add(a_out, b_out, op_out);
    sum_in   = g1[7:0];
    carry_in = g1[8];
    ovf_in   = g1[9];
    if (fault_mode == 1) sum_in[0] = 1'b0;
    if (fault_mode == 2 && inj_mask[vec_count[3:0]]) sum_in = sum_in ^ 8'h01;
    g2     = ref_add(a2, b2, op2);
    sum2   = g2[7:0];
    carry2 = ~g2[8];
    ovf2   = g2[9];
  end

  // Expected vector sequence from the LFSR rule.
  logic [7:0] exp_a [NS];
  logic [7:0] exp_b [NS];
  logic       exp_op[NS];

  task automatic build_model();
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < NS; k++) begin
      exp_a[k]  = l[7:0];
      exp_b[k]  = l[15:8];
      exp_op[k] = k[0];
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  logic [7:0] obs_a [N];
  logic [7:0] obs_b [N];
  logic       obs_op[N];
  int         done_cyc;
  bit         overlap;

  // Starts a run on the 16-vector instance and records operands as they appear.
  task automatic run_capture(input bit poke_busy);
    int c;
    overlap  = 0;
    done_cyc = -1;
    for (int k = 0; k < N; k++) begin
      obs_a[k] = 8'h00; obs_b[k] = 8'h00; obs_op[k] = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b1;
    c = 0;
    while (c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (poke_busy && c >= 2 && c <= 3 * N - 2) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (busy && done) overlap = 1;
      if (c >= 2 && ((c - 2) % 3 == 0) && ((c - 2) / 3 < N) && busy) begin
        obs_a[(c - 2) / 3]  = a_out;
        obs_b[(c - 2) / 3]  = b_out;
        obs_op[(c - 2) / 3] = op_out;
      end
      if (done) begin
        done_cyc = c;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_out !== 8'd0 || b_out !== 8'd0 || op_out !== 1'b0) begin errors++; $display("FAIL reset_operands got %h %h %b want 00 00 0", a_out, b_out, op_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass); end
    checks++; if (err_count !== 8'd0 || vec_count !== 8'd0) begin errors++; $display("FAIL reset_counts got err=%0d vec=%0d want 0 0", err_count, vec_count); end
    @(negedge clk); rst = 1'b0;
    // Start a run, then reset asynchronously in SETTLE of vector 0.
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out !== exp_a[0] || busy !== 1'b1) begin errors++; $display("FAIL settle_entry got A=%h busy=%b want A=%h busy=1", a_out, busy, exp_a[0]); end
    rst = 1'b1; #1;
    checks++; if (a_out !== 8'd0 || b_out !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset got A=%h B=%h busy=%b want 00 00 0", a_out, b_out, busy); end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || a_out !== 8'd0) begin errors++; $display("FAIL idle_hold got busy=%b done=%b A=%h want 0 0 00", busy, done, a_out); end
    $display("reset: checked reset values, async reset in SETTLE, idle hold");
  endtask

  task automatic test_first_vector();
    fault_mode = 0;
    run_capture(1'b0);
    checks++; if (obs_a[0] !== 8'hE1 || obs_b[0] !== 8'hAC || obs_op[0] !== 1'b0) begin errors++; $display("FAIL first_vector got %h %h %b want E1 AC 0", obs_a[0], obs_b[0], obs_op[0]); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL first_vector_err got %0d want 0", err_count); end
    $display("first_vector: A=%h B=%h op=%b", obs_a[0], obs_b[0], obs_op[0]);
  endtask

  task automatic test_full_run();
    int bad;
    fault_mode = 0;
    run_capture(1'b0);
    bad = 0;
    for (int k = 0; k < N; k++)
      if (obs_a[k] !== exp_a[k] || obs_b[k] !== exp_b[k] || obs_op[k] !== exp_op[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_run_sequence got %0d bad vectors want 0", bad); end
    checks++; if (done_cyc != 1 + 3 * N) begin errors++; $display("FAIL full_run_latency got %0d want %0d", done_cyc, 1 + 3 * N); end
    checks++; if (vec_count !== 8'(N) || err_count !== 8'd0 || pass !== 1'b1) begin errors++; $display("FAIL full_run_result got vec=%0d err=%0d pass=%b want %0d 0 1", vec_count, err_count, pass, N); end
    checks++; if (overlap) begin errors++; $display("FAIL busy_done_overlap got 1 want 0"); end
    $display("full_run: done after %0d cycles vec=%0d err=%0d pass=%b", done_cyc, vec_count, err_count, pass);
  endtask

  task automatic test_restart_busy_start();
    int bad;
    fault_mode = 0;
    run_capture(1'b1);
    bad = 0;
    for (int k = 0; k < N; k++)
      if (obs_a[k] !== exp_a[k] || obs_b[k] !== exp_b[k] || obs_op[k] !== exp_op[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_sequence got %0d bad vectors want 0", bad); end
    checks++; if (done_cyc != 1 + 3 * N) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", done_cyc, 1 + 3 * N); end
    checks++; if (vec_count !== 8'(N) || pass !== 1'b1) begin errors++; $display("FAIL restart_result got vec=%0d pass=%b want %0d 1", vec_count, pass, N); end
    $display("restart: random start pokes while busy, done after %0d cycles", done_cyc);
  endtask

  task automatic test_bit0_fault();
    int odd, first;
    logic [9:0] r;
    odd = 0; first = -1;
    for (int k = 0; k < N; k++) begin
      r = ref_add(exp_a[k], exp_b[k], exp_op[k]);
      if (r[0]) begin odd++; if (first < 0) first = k; end
    end
    fault_mode = 1;
    run_capture(1'b0);
    fault_mode = 0;
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    checks++; if (vec_count !== 8'(first + 1) || err_count !== 8'd1) begin errors++; $display("FAIL bit0_stop got vec=%0d err=%0d want %0d 1", vec_count, err_count, first + 1); end
    checks++; if (a_out !== exp_a[first] || b_out !== exp_b[first]) begin errors++; $display("FAIL bit0_stop_operands got %h %h want %h %h", a_out, b_out, exp_a[first], exp_b[first]); end
`else
    checks++; if (err_count !== 8'(odd) || vec_count !== 8'(N)) begin errors++; $display("FAIL bit0_fault got err=%0d vec=%0d want %0d %0d", err_count, vec_count, odd, N); end
`endif
    checks++; if (pass !== (odd == 0)) begin errors++; $display("FAIL bit0_pass got %b want %b", pass, odd == 0); end
    $display("bit0_fault: odd sums=%0d first=%0d err=%0d vec=%0d", odd, first, err_count, vec_count);
  endtask

  task automatic test_random_faults();
    int first, cnt;
    for (int t = 0; t < 3; t++) begin
      inj_mask = 16'($urandom);
      cnt = $countones(inj_mask);
      first = -1;
      for (int k = N - 1; k >= 0; k--) if (inj_mask[k]) first = k;
      fault_mode = 2;
      run_capture(1'b0);
      fault_mode = 0;
`ifdef ADDER_CHK_STOP_ON_ERR_EN
      checks++;
      if (cnt == 0) begin
        if (vec_count !== 8'(N) || err_count !== 8'd0) begin errors++; $display("FAIL rand_stop got vec=%0d err=%0d want %0d 0", vec_count, err_count, N); end
      end else if (vec_count !== 8'(first + 1) || err_count !== 8'd1) begin
        errors++; $display("FAIL rand_stop got vec=%0d err=%0d want %0d 1", vec_count, err_count, first + 1);
      end
`else
      checks++; if (err_count !== 8'(cnt) || vec_count !== 8'(N)) begin errors++; $display("FAIL rand_faults got err=%0d vec=%0d want %0d %0d", err_count, vec_count, cnt, N); end
`endif
      checks++; if (pass !== (cnt == 0)) begin errors++; $display("FAIL rand_pass got %b want %b", pass, cnt == 0); end
      $display("random_faults: mask=%h injected=%0d err=%0d vec=%0d", inj_mask, cnt, err_count, vec_count);
    end
  endtask

  task automatic test_saturation();
    int c;
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    c = 1;
    while (!done2 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    checks++; if (!done2) begin errors++; $display("FAIL sat_timeout got done=0 after %0d cycles want done=1", c); end
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    checks++; if (err2 !== 8'd1 || vec2 !== 8'd1) begin errors++; $display("FAIL sat_stop got err=%0d vec=%0d want 1 1", err2, vec2); end
`else
    checks++; if (err2 !== 8'd255 || vec2 !== 8'd255) begin errors++; $display("FAIL saturation got err=%0d vec=%0d want 255 255", err2, vec2); end
    checks++; if (c != 1 + 3 * NS) begin errors++; $display("FAIL sat_latency got %0d want %0d", c, 1 + 3 * NS); end
`endif
    checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL sat_pass got %b want 0", pass2); end
    $display("saturation: err=%0d vec=%0d after %0d cycles", err2, vec2, c);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    fault_mode = 0;
    inj_mask = 16'h0000;
    build_model();
    test_reset();
    test_first_vector();
    test_full_run();
    test_restart_busy_start();
    test_bit0_fault();
    test_random_faults();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_stim_checker.md
# adder_stim_checker

Self-checking operand source and result monitor for the 8-bit add/subtract unit. It drives operand pairs and an opcode into the adder's A/B/opcode inputs and samples the adder's Sum/Carry/overflow. It compares each result against an internally computed expected value and reports a vector count, an error count and a pass flag. It sits on the opposite side of the adder interface: it is the producer of operands and the consumer of results, and is used for on-chip self-test and for bench regressions.

## Interface
- `NUM_VECTORS`, default 16: number of vectors per run; legal range 1–255.
- `SEED`, default 16'hACE1: LFSR seed loaded on every start; the value 0 is replaced by 16'hACE1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begins a run when sampled high in IDLE or DONE.
- `A_out` output, 8 bits: operand A to the adder; registered.
- `B_out` output, 8 bits: operand B to the adder; registered.
- `opcode_out` output, 1 bit: 0 = add, 1 = subtract (A − B); registered.
- `Sum_in` input, 8 bits: adder Sum.
- `Carry_in` input, 1 bit: adder Carry.
- `overflow_in` input, 1 bit: adder overflow.
- `busy` output, 1 bit: high in DRIVE, SETTLE and CHECK.
- `done` output, 1 bit: high in DONE.
- `pass` output, 1 bit: `done && err_count == 0`.
- `err_count` output, 8 bits: mismatching vectors; saturates at 255.
- `vec_count` output, 8 bits: vectors checked in the current run.

## Operation
- The FSM has five states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- **IDLE**
  - `start` = 1 causes: LFSR ← SEED, `err_count` ← 0, `vec_count` ← 0, next state DRIVE.
- **DRIVE**
  - LFSR advances one step: 16-bit Galois, mask 16'hB400. Shift right; if the old bit0 is 1, XOR the mask.
  - The operands take the pre-advance LFSR value: `A_out` ← lfsr[7:0], `B_out` ← lfsr[15:8], `opcode_out` ← `vec_count[0]`.
  - Next state: SETTLE.
- **SETTLE**
  - One idle cycle to let the combinational adder settle. Next state: CHECK.
- **CHECK**
  - Compute the expected 9-bit result R:
    - opcode 0: R = {0,A} + {0,B}.
    - opcode 1: R = {0,A} + {0,~B} + 1.
  - Expected Sum = R[7:0]; expected Carry = R[8]. For subtract, Carry = 1 means no borrow (A ≥ B unsigned).
  - Expected overflow: `(A[7] == Beff[7]) && (Sum[7] != A[7])`, where Beff = B for add and ~B for subtract.
  - Any mismatch in Sum_in, Carry_in or overflow_in increments `err_count` (saturating). `vec_count` increments every CHECK.
  - Next state: DONE if the new `vec_count` equals NUM_VECTORS, otherwise DRIVE.
- **DONE**
  - Outputs and counters hold. `start` = 1 reseeds and goes to DRIVE exactly as from IDLE.
- `start` is ignored while `busy`.
- On reset, including mid-run, the state, LFSR, counters and all outputs return to their reset values immediately.

## Timing
- Reset values: state IDLE, LFSR = SEED, `A_out` = 0, `B_out` = 0, `opcode_out` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `vec_count` = 0.
- Each vector takes 3 cycles: DRIVE, SETTLE, CHECK.
- A run takes 1 + 3·NUM_VECTORS cycles from the `start` edge to `done` rising. The 1 is the IDLE/DONE cycle that samples `start`.
- Operands change only on the DRIVE→SETTLE edge and are stable through SETTLE and CHECK.
- The adder inputs are sampled only in CHECK; the adder must be combinational within 1 cycle.
- `busy` and `done` are never high together.
- `err_count` and `vec_count` update on the CHECK→next edge.

## Configuration
- `ADDER_CHK_STOP_ON_ERR_EN` defined:
  - The first mismatch moves CHECK → DONE. `vec_count` then holds the 1-based index of the failing vector. `A_out`, `B_out` and `opcode_out` hold the failing operands.
- `ADDER_CHK_STOP_ON_ERR_EN` undefined:
  - All NUM_VECTORS vectors always run; errors only accumulate.

## Test plan
- **Reset:** assert `rst` mid-SETTLE → the same cycle, all outputs go to reset values; after `rst` deasserts, the FSM stays in IDLE until `start`.
- **First vector, golden adder, SEED = 16'hACE1:** `start` → `A_out` = 8'hE1, `B_out` = 8'hAC, `opcode_out` = 0; expected Sum 8'h8D, Carry 1, overflow 0; no error.
- **Full run, golden adder, NUM_VECTORS = 16:** `done` rises exactly 49 cycles after the `start` edge; `vec_count` = 16, `err_count` = 0, `pass` = 1.
- **Overflow/subtract checks in the bench model:** A = 100, B = 100, sub → Sum 0, Carry 1, overflow 0. A = 100, B = 100, add → Sum 200, Carry 0, overflow 1. Both must check clean.
- **Faulty adder (Sum bit0 forced to 0), 16 vectors:** `err_count` equals the number of vectors with an odd expected Sum; `pass` = 0. With `ADDER_CHK_STOP_ON_ERR_EN`, the run stops at the first such vector with `vec_count` equal to its index.
- **Restart and saturation:** `start` in DONE → counters clear and the identical vector sequence repeats. `start` while `busy` → no effect. NUM_VECTORS = 255 with Carry_in stuck-inverted → `err_count` = 255, with no wrap.
